// File: rtl/bram_port_arbiter_if.sv
// One requester-side link to the BRAM port arbiter: request handshake plus read return.
// The requester drives valid/wr/addr/wdata and holds them until it sees ready.
interface bram_port_arbiter_if #(
    parameter int ADDR_BITS = 11,
    parameter int DATA_BITS = 16
);
    logic                 valid;
    logic                 ready;
    logic                 wr;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] wdata;
    logic                 rvalid;
    logic [DATA_BITS-1:0] rdata;

    modport master (output valid, output wr, output addr, output wdata,
                    input  ready, input  rvalid, input  rdata);
    modport slave  (input  valid, input  wr, input  addr, input  wdata,
                    output ready, output rvalid, output rdata);
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one registered-read BRAM port between two requesters,
// with an optional memory clear sequence after reset.
module bram_port_arbiter #(
    parameter int ADDR_BITS      = 11,
    parameter int DATA_BITS      = 16,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    bram_port_arbiter_if.slave   r0,
    bram_port_arbiter_if.slave   r1,
    output logic                 mem_wr,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_din,
    input  logic [DATA_BITS-1:0] mem_dout,
    output logic                 init_done,
    output logic                 dbg_state
);
    // Handshake: a request transfers in a cycle where valid and ready are both high;
    // ready is combinational, at most one requester sees it, and never without valid.
    typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;
    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 1'b0) ? S_INIT : S_RUN;

    state_t               state;
    logic [ADDR_BITS-1:0] cnt;
    logic                 last_grant;
    logic [1:0]           tag_v;
    logic [1:0]           tag_id;

    logic                 run;
    logic                 g0, g1;
    logic                 accept, sel;
    logic                 req_wr;
    logic [ADDR_BITS-1:0] req_addr;
    logic [DATA_BITS-1:0] req_wdata;
    logic                 rd_accept;

    // On a tie the requester that did not win last time goes next.
    assign run       = (state == S_RUN) && !rst;
    assign g0        = r0.valid && (!r1.valid || last_grant);
    assign g1        = r1.valid && (!r0.valid || !last_grant);
    assign r0.ready  = run && g0;
    assign r1.ready  = run && g1;
    assign accept    = r0.ready || r1.ready;
    assign sel       = r1.ready;
    assign req_wr    = sel ? r1.wr    : r0.wr;
    assign req_addr  = sel ? r1.addr  : r0.addr;
    assign req_wdata = sel ? r1.wdata : r0.wdata;
    assign rd_accept = accept && !req_wr;

    // Stage 1 covers the registered address, stage 2 the BRAM's output register.
    assign r0.rvalid = tag_v[1] && !tag_id[1];
    assign r1.rvalid = tag_v[1] &&  tag_id[1];
    assign r0.rdata  = mem_dout;
    assign r1.rdata  = mem_dout;

    assign init_done = (state == S_RUN);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RESET_STATE;
            cnt        <= '0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            last_grant <= 1'b1;
            tag_v      <= '0;
            tag_id     <= '0;
        end else begin
            tag_v  <= {tag_v[0], rd_accept};
            tag_id <= {tag_id[0], sel};
            case (state)
                S_INIT: begin
                    mem_wr   <= 1'b1;
                    mem_din  <= '0;
                    mem_addr <= cnt;
                    cnt      <= cnt + 1'b1;
                    if (cnt == {ADDR_BITS{1'b1}}) state <= S_RUN;
                end
                default: begin
                    mem_wr <= accept && req_wr;
                    if (accept) begin
                        mem_addr   <= req_addr;
                        mem_din    <= req_wdata;
                        last_grant <= sel;
                    end
                end
            endcase
        end
    end
endmodule
